// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit, MUL_BPC/DIV_BPC result bits per cycle,
// one operation in flight, result held until the consumer takes it.
module muldiv_unit #(
    parameter int XLEN    = 64,
    parameter int MUL_BPC = 1,
    parameter int DIV_BPC = 1,
    parameter int TAG_W   = 64,
    parameter bit HAS_W   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_t state;
    logic [XLEN-1:0] hi, lo, b;
    logic [6:0] cnt;
    logic is_div, want_alt, neg, word;

    logic accept, d_word, d_div, d_s1, d_s2, d_alt, d_neg, a_neg, b_neg;
    logic d_illegal, d_zero, d_ovf, d_fast;
    logic [2:0] f3;
    logic [6:0] d_cnt;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd, fast_res;

    assign f3 = in_op[2:0];
    assign d_word = in_op[3];
    assign d_div = f3[2];
    assign d_alt = d_div ? f3[1] : (f3 != 3'd0);
    assign d_s1 = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    assign d_s2 = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    assign a_ext = d_word ? (d_s1 ? sx(in_op1[31:0]) : XLEN'(in_op1[31:0])) : in_op1;
    assign b_ext = d_word ? (d_s2 ? sx(in_op2[31:0]) : XLEN'(in_op2[31:0])) : in_op2;
    assign a_neg = d_s1 && a_ext[XLEN-1];
    assign b_neg = d_s2 && b_ext[XLEN-1];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;
    // remainder takes the dividend's sign, everything else the product of signs
    assign d_neg = (d_div && f3[1]) ? a_neg : a_neg ^ b_neg;
    assign d_illegal = d_word && (!HAS_W || (!d_div && f3 != 3'd0));
    assign d_zero = d_div && b_ext == '0;
    assign d_ovf = d_div && !f3[0] && (d_word ? (in_op1[31:0] == 32'h8000_0000 && &in_op2[31:0])
                                              : (in_op1 == MIN_X && &in_op2));
    assign d_fast = d_illegal || d_zero || d_ovf;
    assign dvd = d_word ? sx(in_op1[31:0]) : in_op1;
    assign fast_res = d_illegal ? '0 : d_zero ? (f3[1] ? dvd : '1) : (f3[1] ? '0 : dvd);
    assign d_cnt = 7'((d_word ? 32 : XLEN) / (d_div ? DIV_BPC : MUL_BPC));

    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;

    logic [XLEN-1:0] m_hi, m_lo, d_hi, d_lo, n_hi, n_lo;
    logic [XLEN:0] m_sum, d_rem;
    logic d_ge;

    // shift-add: multiplier in lo drains out the bottom as the product fills in from the top
    always_comb begin
        m_hi = hi;
        m_lo = lo;
        m_sum = '0;
        for (int i = 0; i < MUL_BPC; i++) begin
            m_sum = {1'b0, m_hi} + (m_lo[0] ? {1'b0, b} : '0);
            m_hi = m_sum[XLEN:1];
            m_lo = {m_sum[0], m_lo[XLEN-1:1]};
        end
    end

    // restoring division: hi holds the partial remainder, lo the dividend shifting into quotient
    always_comb begin
        d_hi = hi;
        d_lo = lo;
        d_rem = '0;
        d_ge = 1'b0;
        for (int i = 0; i < DIV_BPC; i++) begin
            d_rem = {d_hi, d_lo[XLEN-1]};
            d_ge = d_rem >= {1'b0, b};
            d_hi = d_ge ? XLEN'(d_rem - {1'b0, b}) : d_rem[XLEN-1:0];
            d_lo = {d_lo[XLEN-2:0], d_ge};
        end
    end

    assign n_hi = is_div ? d_hi : m_hi;
    assign n_lo = is_div ? d_lo : m_lo;

    logic [2*XLEN-1:0] prod, prod_w, pn;
    logic [XLEN-1:0] dv, dn, calc_res;
    assign prod = {n_hi, n_lo};
    assign prod_w = word ? prod >> (XLEN - 32) : prod;
    assign pn = neg ? -prod_w : prod_w;
    assign dv = want_alt ? n_hi : n_lo;
    assign dn = neg ? -dv : dv;
    assign calc_res = is_div ? (word ? sx(dn[31:0]) : dn)
                    : word ? sx(pn[31:0]) : (want_alt ? pn[2*XLEN-1:XLEN] : pn[XLEN-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi <= '0;
            lo <= '0;
            b <= '0;
            cnt <= '0;
            is_div <= 1'b0;
            want_alt <= 1'b0;
            neg <= 1'b0;
            word <= 1'b0;
            out_result <= '0;
            out_tag <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            state <= d_fast ? DONE : CALC;
            out_tag <= in_tag;
            if (d_fast)
                out_result <= fast_res;
            hi <= '0;
            lo <= (d_div && d_word) ? a_mag << (XLEN - 32) : a_mag;
            b <= b_mag;
            cnt <= d_cnt;
            is_div <= d_div;
            want_alt <= d_alt;
            neg <= d_neg;
            word <= d_word;
        end else if (state == CALC) begin
            hi <= n_hi;
            lo <= n_lo;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) begin
                state <= DONE;
                out_result <= calc_res;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a wide-arithmetic reference.
module tb_muldiv_unit;
    logic clk = 0;
    logic reset = 1;
    logic flush = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [3:0] in_op = 0;
    logic [63:0] in_op1 = 0, in_op2 = 0, in_tag = 0;
    logic out_valid, out_ready = 1, busy;
    logic [63:0] out_result, out_tag;

    int n_tests = 0, n_fail = 0, cyc = 0;

    muldiv_unit #(.XLEN(64), .MUL_BPC(1), .DIV_BPC(1), .TAG_W(64), .HAS_W(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M semantics via 130-bit signed arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] as_v, au, bs, bu, r;
        int w;
        w = op[3] ? 32 : 64;
        as_v = op[3] ? {{98{a[31]}}, a[31:0]} : {{66{a[63]}}, a};
        au = op[3] ? {98'b0, a[31:0]} : {66'b0, a};
        bs = op[3] ? {{98{b[31]}}, b[31:0]} : {{66{b[63]}}, b};
        bu = op[3] ? {98'b0, b[31:0]} : {66'b0, b};
        if (op[3] && op[2:0] != 3'd0 && !op[2])
            return 64'd0;
        case (op[2:0])
            3'd0: r = as_v * bs;
            3'd1: r = (as_v * bs) >>> w;
            3'd2: r = (as_v * bu) >>> w;
            3'd3: r = (au * bu) >>> w;
            3'd4: if (bu == 0) r = -1; else r = as_v / bs;
            3'd5: if (bu == 0) r = -1; else r = au / bu;
            3'd6: if (bu == 0) r = as_v; else r = as_v % bs;
            default: if (bu == 0) r = au; else r = au % bu;
        endcase
        return op[3] ? {{32{r[31]}}, r[31:0]} : r[63:0];
    endfunction

    // Number of CALC cycles: 0 on the fast paths, else the operand width.
    function automatic int k_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic zero, mn, m1;
        zero = op[3] ? b[31:0] == 32'd0 : b == 64'd0;
        mn = op[3] ? a[31:0] == 32'h8000_0000 : a == 64'h8000_0000_0000_0000;
        m1 = op[3] ? &b[31:0] : &b;
        if (op[3] && op[2:0] != 3'd0 && !op[2])
            return 0;
        if (op[2] && (zero || (!op[0] && mn && m1)))
            return 0;
        return op[3] ? 32 : 64;
    endfunction

    typedef struct {
        logic [63:0] tag;
        logic [63:0] res;
        int due;
    } exp_t;
    exp_t q[$];

    // Scoreboard: every cycle, the DUT must match the single expected operation (or be idle).
    always @(negedge clk) begin
        logic exp_rdy;
        if (!reset) begin
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_result", out_result, 64'd0);
            chk("rst_tag", out_tag, 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            q.delete();
        end else begin
            if (q.size() == 0) begin
                exp_rdy = !flush;
                chk("idle_valid", 64'(out_valid), 64'd0);
                chk("idle_busy", 64'(busy), 64'd0);
            end else begin
                exp_rdy = !flush && cyc >= q[0].due && out_ready;
                chk("busy", 64'(busy), 64'd1);
                if (cyc < q[0].due) begin
                    chk("early_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("valid", 64'(out_valid), 64'd1);
                    chk("result", out_result, q[0].res);
                    chk("tag", out_tag, q[0].tag);
                end
            end
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (q.size() != 0 && (flush || (cyc >= q[0].due && out_ready)))
                void'(q.pop_front());
            if (in_valid && exp_rdy)
                q.push_back('{tag: in_tag, res: model(in_op, in_op1, in_op2),
                              due: cyc + 1 + k_of(in_op, in_op1, in_op2)});
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] tag, output int tries);
        logic ok;
        ok = 0;
        tries = 0;
        in_valid = 1;
        in_op = op;
        in_op1 = a;
        in_op2 = b;
        in_tag = tag;
        while (!ok && tries < 300) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic await_res(input string nm, input logic [63:0] tag, input logic [63:0] exp, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 64'(n + 1), 64'(lat));
        chk({nm, "_res"}, out_result, exp);
        chk({nm, "_tag"}, out_tag, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] tag, input logic [63:0] exp, input int lat);
        int t;
        issue(op, a, b, tag, t);
        await_res(nm, tag, exp, lat);
    endtask

    function automatic logic [63:0] rval();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return {$urandom, 32'h8000_0000};
            5: return {32'd0, $urandom};
            6: return 64'($urandom_range(0, 40)) - 64'd20;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int t;
        chk("model_mul", model(4'd0, 64'd7, -64'd3), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_mulhu", model(4'd3, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_div", model(4'd4, -64'd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_rem", model(4'd6, -64'd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_divw_ovf", model(4'b1100, 64'h0000_0001_8000_0000, '1), 64'hFFFF_FFFF_8000_0000);
        chk("model_remu0", model(4'd7, 64'd100, 64'd0), 64'd100);
        chk("model_mulhsu", model(4'd2, -64'd1, '1), 64'hFFFF_FFFF_FFFF_FFFF);

        #2 reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        run("mul", 4'd0, 64'd7, -64'd3, 64'h11, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run("mulhu", 4'd3, '1, '1, 64'h12, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("div", 4'd4, -64'd7, 64'd2, 64'h13, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem", 4'd6, -64'd7, 64'd2, 64'h14, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("divw_ovf", 4'b1100, 64'h0000_0001_8000_0000, '1, 64'h15, 64'hFFFF_FFFF_8000_0000, 1);
        run("divu0", 4'd5, 64'd100, 64'd0, 64'h16, '1, 1);
        run("remu0", 4'd7, 64'd100, 64'd0, 64'h17, 64'd100, 1);
        run("mulhw_illegal", 4'b1001, 64'd5, 64'd5, 64'h18, 64'd0, 1);

        out_ready = 0;
        issue(4'd0, 64'd6, 64'd7, 64'h55, t);
        await_res("hold0", 64'h55, 64'd42, 65);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_res", out_result, 64'd42);
            chk("hold_tag", out_tag, 64'h55);
            chk("hold_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        issue(4'd5, 64'd100, 64'd7, 64'h66, t);
        chk("b2b_same_cycle", 64'(t), 64'd1);
        await_res("b2b", 64'h66, 64'd14, 65);

        issue(4'd0, 64'd5, 64'd5, 64'hF1, t);
        repeat (9) @(posedge clk);
        #1;
        flush = 1;
        in_valid = 1;
        in_op = 4'd0;
        in_tag = 64'hF2;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 0;
        in_valid = 0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        run("mulw", 4'b1000, 64'd3, 64'd4, 64'h34, 64'd12, 33);

        issue(4'd0, 64'd9, 64'd9, 64'h77, t);
        repeat (5) @(posedge clk);
        #1 reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_result", out_result, 64'd0);
        chk("post_rst_tag", out_tag, 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 20000; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_op = 4'($urandom_range(0, 15));
            in_op1 = rval();
            in_op2 = rval();
            in_tag = {$urandom, $urandom};
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 299) == 0;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        flush = 0;
        out_ready = 1;
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution unit, attached beside the single-cycle ALU in the execute stage.
- Accepts one M-extension operation at a time over a valid/ready handshake and computes it over multiple cycles, BPC result bits per cycle.
- Holds the result until the downstream stage takes it.
- The execute stage drives its own `ok` low while this unit is busy or holding an unaccepted result.

Parameters:
- XLEN, 64: operand and result width. Legal values are 32 and 64.
- MUL_BPC, 1: multiplier bits retired per CALC cycle. Must divide 32.
- DIV_BPC, 1: quotient bits produced per CALC cycle. Must divide 32.
- TAG_W, 64: width of the opaque tag carried with each operation (the instruction counter).
- HAS_W, 1: enables the 32-bit word variants. Must be 0 when XLEN=32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous abort of the in-flight or held operation.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  4  {is_word, funct3}. funct3 codes: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_op1  input  XLEN  rs1 value, already forwarded.
- in_op2  input  XLEN  rs2 value, already forwarded.
- in_tag  input  TAG_W  tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_result  output  XLEN  result.
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - out_valid=0, out_result=0, out_tag=0, busy=0.
  - All internal registers cleared.
  - Reset may arrive in any state; the operation is discarded with no output.
- FSM states: IDLE, CALC, DONE.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)). Accept = in_valid && in_ready.
- Accept from IDLE, or from DONE in the same cycle the held result is taken (back-to-back operation):
  - Latch the operation, operands and tag.
  - Go to CALC with iteration count k = W/BPC, where W=32 if is_word and W=XLEN otherwise.
  - For the fast-path cases, go directly to DONE instead (k=0).
- Fast paths, all division class:
  - Divisor = 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
  - Both fast paths apply to the word variants on the 32-bit operands.
- CALC:
  - One step per cycle. Counter decrements; at the step with counter==1, go to DONE with the result registered.
  - out_valid rises exactly k+1 cycles after the acceptance cycle (fast path: 1 cycle).
- Signed operations:
  - Compute on magnitudes, unsigned; negate the final result when required.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - MULHSU treats only op1 as signed.
- Multiply:
  - Full 2*W-bit product.
  - MUL returns the low W bits. MULH, MULHSU and MULHU return the high W bits.
- Word ops (is_word=1, HAS_W=1):
  - Operands are the low 32 bits, sign- or zero-extended per op.
  - The 32-bit result is sign-extended to XLEN.
  - Legal is_word funct3 codes: 0, 4, 5, 6, 7.
  - The other is_word codes, and any is_word with HAS_W=0, complete as fast path with result 0.
- DONE:
  - out_valid=1; out_result and out_tag are stable while out_ready=0.
  - out_ready=1 and no new accept: go to IDLE, out_valid=0 next cycle.
- flush (priority over everything except reset):
  - Next state IDLE; out_valid=0 next cycle.
  - in_valid in a flush cycle is ignored (in_ready=0).
  - A result presented with out_ready=1 in a flush cycle still counts as taken by the consumer; the unit's state is IDLE regardless.
- busy = (state != IDLE).

Test Plan:
- Reset held low for 3 cycles mid-CALC, then released → all outputs 0, in_ready=1 in the first cycle after release.
- MUL 7 × −3 (XLEN=64, BPC=1), out_ready=1 → out_valid exactly 65 cycles after accept, result 0xFFFFFFFFFFFFFFEB, tag echoed. MULHU all-ones × all-ones → 0xFFFFFFFFFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFFFFFFFFFD; REM −7/2 → 0xFFFFFFFFFFFFFFFF. DIVW with op1=0x0000000180000000, op2=−1 → overflow fast path, 0xFFFFFFFF80000000, 1 cycle.
- DIVU 100/0 → 0xFFFFFFFFFFFFFFFF after 1 cycle; REMU 100/0 → 100.
- Hold out_ready=0 for 5 cycles in DONE → result and tag stable, in_ready=0. Then out_ready=1 with in_valid=1 → next op accepted in the same cycle.
- flush on CALC cycle 10 → IDLE next cycle, no out_valid ever for that tag. A following MULW 3×4 returns 12 after 33 cycles.
